// File: rtl/motor_cmd_spi_rx.sv
// SPI-slave receiver for 16-bit motor command frames: decodes, clamps and latches the
// motor bus, runs a loss-of-link watchdog, and echoes the active command on sdo.
module motor_cmd_spi_rx #(
    parameter logic [6:0]  MAX_COUNT      = 7'd100,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd600000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       sdi,
    output logic       sdo,
    output logic       motor1_sign,
    output logic [6:0] motor1_count,
    output logic       motor2_sign,
    output logic [6:0] motor2_count,
    output logic       cmd_valid,
    output logic       frame_error,
    output logic       timeout
);

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned WD_W    = 24;
    localparam logic [CNT_W-1:0] BITS_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] BITS_SAT  = CNT_W'(FRAME_W + 1);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, COMMIT} state_t;

    state_t             state, state_nxt;
    logic [2:0]         sck_sync;
    logic [2:0]         cs_sync;
    logic [1:0]         sdi_sync;
    logic [FRAME_W-1:0] shift_q;
    logic [FRAME_W-1:0] echo_q;
    logic [CNT_W-1:0]   bit_cnt;
    logic [WD_W-1:0]    wd_q;
    logic [WD_W-1:0]    wd_nxt_c;

    logic sck_rise_c, sck_fall_c, cs_rise_c, cs_fall_c;
    logic start_c, shift_en_c, echo_shift_c, commit_c;
    logic frame_ok_c, frame_bad_c;
    logic [6:0] m1_clamp_c, m2_clamp_c;

    // Two-flop synchronizers plus a third flop on sck/cs_n for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync <= '0;
            cs_sync  <= '0;
            sdi_sync <= '0;
        end else begin
            sck_sync <= {sck_sync[1:0], sck};
            cs_sync  <= {cs_sync[1:0], cs_n};
            sdi_sync <= {sdi_sync[0], sdi};
        end
    end

    assign sck_rise_c =  sck_sync[1] & ~sck_sync[2];
    assign sck_fall_c = ~sck_sync[1] &  sck_sync[2];
    assign cs_rise_c  =  cs_sync[1]  & ~cs_sync[2];
    assign cs_fall_c  = ~cs_sync[1]  &  cs_sync[2];

    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_IDLE;
        else       state <= state_nxt;
    end

    // A cs_n edge in SHIFT masks any sck edge detected in the same cycle
    always_comb begin
        state_nxt    = state;
        start_c      = 1'b0;
        shift_en_c   = 1'b0;
        echo_shift_c = 1'b0;
        commit_c     = 1'b0;
        case (state)
            WAIT_IDLE: if (cs_sync[1]) state_nxt = IDLE;
            IDLE: begin
                if (cs_fall_c) begin
                    state_nxt = SHIFT;
                    start_c   = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise_c) begin
                    state_nxt = COMMIT;
                end else begin
                    shift_en_c   = sck_rise_c;
                    echo_shift_c = sck_fall_c;
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
                commit_c  = 1'b1;
            end
            default: state_nxt = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (start_c) begin
            bit_cnt <= '0;
        end else if (shift_en_c) begin
            shift_q <= {shift_q[FRAME_W-2:0], sdi_sync[1]};
            if (bit_cnt != BITS_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // Echo shifter is held at zero outside a frame so sdo idles low
    always_ff @(posedge clk) begin
        if (reset) begin
            echo_q <= '0;
        end else if (start_c) begin
            echo_q <= {motor1_sign, motor1_count, motor2_sign, motor2_count};
        end else if (state != SHIFT || cs_rise_c) begin
            echo_q <= '0;
        end else if (echo_shift_c) begin
            echo_q <= {echo_q[FRAME_W-2:0], 1'b0};
        end
    end

    assign sdo = echo_q[FRAME_W-1];

    assign frame_ok_c  = commit_c && (bit_cnt == BITS_FULL);
    assign frame_bad_c = commit_c && (bit_cnt != BITS_FULL);
    assign m1_clamp_c  = (shift_q[14:8] > MAX_COUNT) ? MAX_COUNT : shift_q[14:8];
    assign m2_clamp_c  = (shift_q[6:0]  > MAX_COUNT) ? MAX_COUNT : shift_q[6:0];
    assign wd_nxt_c    = (wd_q == '1) ? wd_q : wd_q + WD_W'(1);

    // Output bus and watchdog; a valid commit overrides a coincident expiry
    always_ff @(posedge clk) begin
        if (reset) begin
            motor1_sign  <= 1'b0;
            motor1_count <= '0;
            motor2_sign  <= 1'b0;
            motor2_count <= '0;
            cmd_valid    <= 1'b0;
            frame_error  <= 1'b0;
            timeout      <= 1'b0;
            wd_q         <= '0;
        end else begin
            cmd_valid   <= frame_ok_c;
            frame_error <= frame_bad_c;
            if (frame_ok_c) begin
                motor1_sign  <= shift_q[15];
                motor1_count <= m1_clamp_c;
                motor2_sign  <= shift_q[7];
                motor2_count <= m2_clamp_c;
                timeout      <= 1'b0;
                wd_q         <= '0;
            end else begin
                wd_q <= wd_nxt_c;
                if (wd_nxt_c >= TIMEOUT_CYCLES) begin
                    timeout      <= 1'b1;
                    motor1_count <= '0;
                    motor2_count <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_motor_cmd_spi_rx.sv
// Scoreboard bench for motor_cmd_spi_rx: frames push expected commits/errors with their
// due cycle; a monitor pops and checks each cmd_valid/frame_error pulse.
module tb_motor_cmd_spi_rx;

    localparam int unsigned HALF = 4;

    logic       clk = 1'b0;
    logic       reset, sck, cs_n, sdi;
    logic       sdo, motor1_sign, motor2_sign, cmd_valid, frame_error, timeout;
    logic [6:0] motor1_count, motor2_count;

    typedef struct {
        bit          is_err;
        logic        m1s;
        logic [6:0]  m1c;
        logic        m2s;
        logic [6:0]  m2c;
        int unsigned at;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int unsigned last_at = 0;
    int          tot = 0;
    int          bad = 0;
    logic [15:0] echo_got;
    logic        mm1s, mm2s;
    logic [6:0]  mm1c, mm2c;

    motor_cmd_spi_rx #(
        .MAX_COUNT      (7'd100),
        .TIMEOUT_CYCLES (24'd1000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sck          (sck),
        .cs_n         (cs_n),
        .sdi          (sdi),
        .sdo          (sdo),
        .motor1_sign  (motor1_sign),
        .motor1_count (motor1_count),
        .motor2_sign  (motor2_sign),
        .motor2_count (motor2_count),
        .cmd_valid    (cmd_valid),
        .frame_error  (frame_error),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
        tot++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    function automatic logic [6:0] clampf(input logic [6:0] v);
        return (v > 7'd100) ? 7'd100 : v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int unsigned n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_bus(input string tag, input logic s1, input logic [6:0] c1,
                             input logic s2, input logic [6:0] c2);
        check({tag, "_m1_sign"},  32'(motor1_sign),  32'(s1));
        check({tag, "_m1_count"}, 32'(motor1_count), 32'(c1));
        check({tag, "_m2_sign"},  32'(motor2_sign),  32'(s2));
        check({tag, "_m2_count"}, 32'(motor2_count), 32'(c2));
    endtask

    // kind: 0 = commit expected, 1 = frame_error expected, 2 = no pulse expected
    task automatic send(input logic [16:0] data, input int n, input int rst_at,
                        input bit simul, input int kind);
        exp_t e;
        echo_got = '0;
        cs_n = 1'b0;
        tick(HALF);
        for (int i = n - 1; i >= 0; i--) begin
            if (rst_at == n - 1 - i) begin
                reset = 1'b1;
                tick(2);
                reset = 1'b0;
                check_bus("midrst", 1'b0, 7'd0, 1'b0, 7'd0);
                check("midrst_sdo", 32'(sdo), 32'd0);
                check("midrst_timeout", 32'(timeout), 32'd0);
                {mm1s, mm1c, mm2s, mm2c} = '0;
            end
            sdi = data[i];
            tick(HALF);
            echo_got = {echo_got[14:0], sdo};
            sck = 1'b1;
            tick(HALF);
            sck = 1'b0;
        end
        sdi = 1'b0;
        tick(HALF);
        if (simul) sck = 1'b1;
        cs_n = 1'b1;
        last_at = cyc + 4;
        if (kind == 0) begin
            mm1s = data[15];
            mm1c = clampf(data[14:8]);
            mm2s = data[7];
            mm2c = clampf(data[6:0]);
        end
        e.is_err = (kind == 1);
        e.m1s = mm1s; e.m1c = mm1c; e.m2s = mm2s; e.m2c = mm2c;
        e.at = last_at;
        if (kind != 2) sb.push_back(e);
        tick(HALF);
        sck = 1'b0;
        tick(8);
    endtask

    // Monitor: each pulse must match the oldest expectation, in kind, cycle and bus
    always @(posedge clk) begin
        #1;
        if (cmd_valid || frame_error) begin
            if (sb.size() == 0) begin
                tot++;
                bad++;
                $display("FAIL unexpected_pulse: cmd_valid=%0b frame_error=%0b want none (cycle %0d)",
                         cmd_valid, frame_error, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_kind", 32'({cmd_valid, frame_error}), mon_e.is_err ? 32'd1 : 32'd2);
                check("pulse_cycle", 32'(cyc), 32'(mon_e.at));
                check("pulse_m1_sign",  32'(motor1_sign),  32'(mon_e.m1s));
                check("pulse_m1_count", 32'(motor1_count), 32'(mon_e.m1c));
                check("pulse_m2_sign",  32'(motor2_sign),  32'(mon_e.m2s));
                check("pulse_m2_count", 32'(motor2_count), 32'(mon_e.m2c));
            end
        end
    end

    initial begin
        reset = 1'b1;
        sck   = 1'b0;
        cs_n  = 1'b1;
        sdi   = 1'b0;
        {mm1s, mm1c, mm2s, mm2c} = '0;
        tick(4);
        check_bus("reset", 1'b0, 7'd0, 1'b0, 7'd0);
        check("reset_sdo", 32'(sdo), 32'd0);
        check("reset_cmd_valid", 32'(cmd_valid), 32'd0);
        check("reset_frame_error", 32'(frame_error), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;
        tick(4);

        send(17'h0E432, 16, -1, 1'b0, 0);
        send(17'h07FFF, 16, -1, 1'b0, 0);
        send(17'h00102, 16, -1, 1'b0, 0);
        check("echo_after_clamp", 32'(echo_got), 32'h64E4);

        send(17'h01234, 15, -1, 1'b0, 1);
        send(17'h1ABCD, 17, -1, 1'b0, 1);
        check_bus("after_errors", 1'b0, 7'd1, 1'b0, 7'd2);
        send(17'h03344, 16, -1, 1'b0, 0);

        // Watchdog trips exactly 1000 cycles after the commit edge
        send(17'h0E4B2, 16, -1, 1'b0, 0);
        wait_cyc(last_at + 999);
        check("wd_before_trip", 32'(timeout), 32'd0);
        check("wd_before_m1_count", 32'(motor1_count), 32'd100);
        wait_cyc(last_at + 1000);
        check("wd_trip", 32'(timeout), 32'd1);
        check_bus("wd_trip", 1'b1, 7'd0, 1'b1, 7'd0);
        mm1c = 7'd0;
        mm2c = 7'd0;
        send(17'h00583, 16, -1, 1'b0, 0);
        check("echo_timed_out", 32'(echo_got), 32'h8080);
        check("timeout_cleared", 32'(timeout), 32'd0);

        send(17'h0FFFF, 16, 8, 1'b0, 2);
        check("echo_midrst", 32'(echo_got), 32'h0500);
        check_bus("after_midrst", 1'b0, 7'd0, 1'b0, 7'd0);
        send(17'h01122, 16, -1, 1'b0, 0);
        check("echo_after_rst", 32'(echo_got), 32'h0000);

        send(17'h0817F, 16, -1, 1'b1, 0);
        check_bus("simul_edges", 1'b1, 7'd1, 1'b0, 7'd100);

        tick(10);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule

// File: doc/motor_cmd_spi_rx.md
# motor_cmd_spi_rx

SPI-slave command receiver that sits between the balance microcontroller and `motor_controller`. It takes 16-bit command frames over SPI and decodes them into the `motor1_sign/motor1_count/motor2_sign/motor2_count` bus that `motor_controller` consumes. It applies a count clamp and a loss-of-link watchdog. It echoes the active command back on `sdo` so the MCU can verify delivery.

## Interface
Parameters:
- `MAX_COUNT`, 7'd100: upper clamp applied to each decoded count (PWM full scale).
- `TIMEOUT_CYCLES`, 24'd600000: `clk` cycles without a valid frame before the watchdog trips.

Ports:
- `clk`, input, 1: system clock, the divided clock that also feeds `motor_controller`.
- `reset`, input, 1: synchronous, active-high.
- `sck`, input, 1: SPI clock from the MCU, mode 0 (idle low, sample on rising edge). Asynchronous to `clk`.
- `cs_n`, input, 1: SPI chip select, active low. Asynchronous.
- `sdi`, input, 1: MOSI. Asynchronous.
- `sdo`, output, 1: MISO, the echo of the active command.
- `motor1_sign`, output, 1: motor 1 direction.
- `motor1_count`, output, 7: motor 1 duty count, range 0..MAX_COUNT.
- `motor2_sign`, output, 1: motor 2 direction.
- `motor2_count`, output, 7: motor 2 duty count, range 0..MAX_COUNT.
- `cmd_valid`, output, 1: one-cycle pulse when a new command is committed.
- `frame_error`, output, 1: one-cycle pulse when a frame is discarded.
- `timeout`, output, 1: level signal; high while the watchdog has tripped.

## Operation
- **Synchronisation**: `sck`, `cs_n` and `sdi` each pass through a 2-flop synchronizer. A third flop on `sck` and `cs_n` provides edge detection. `clk` must be at least 8x the `sck` frequency.
- **Frame format**: 16 bits, MSB first.
  - bits[15:8] = {motor1_sign, motor1_count[6:0]}
  - bits[7:0] = {motor2_sign, motor2_count[6:0]}
- **FSM states**:
  - WAIT_IDLE: entered on reset. Moves to IDLE once synced `cs_n` is 1. This prevents joining a frame that is already in progress.
  - IDLE: on `cs_n` falling edge, clear the bit counter, load the echo shifter, go to SHIFT.
  - SHIFT: on each `sck` rising edge, shift synced `sdi` into a 16-bit register and increment a 5-bit counter, which saturates at 17. On `cs_n` rising edge, go to COMMIT.
  - COMMIT: one cycle, then return to IDLE.
    - Bit count exactly 16: latch the decoded fields, pulse `cmd_valid`, clear the watchdog and `timeout`.
    - Any other bit count (fewer than 16, or more than 16): pulse `frame_error` and leave the outputs unchanged.
- **Clamp**: each count is set to min(received, MAX_COUNT) before latching. Example: 7'd127 becomes 7'd100. Signs pass through unmodified.
- **Watchdog**:
  - A 24-bit counter increments every cycle and saturates.
  - When it reaches TIMEOUT_CYCLES, `timeout` goes to 1, both counts are forced to 0, and the signs are held.
  - It is cleared only by a committed frame. Error frames do not feed it.
- **Echo**:
  - On `cs_n` falling edge, the shifter loads the current output bus in frame format, post-clamp and post-timeout.
  - `sdo` drives shifter[15]. The shifter shifts left on each synced `sck` falling edge.
  - `sdo` is 0 while `cs_n` is high.
- **Simultaneous events**:
  - `sck` and `cs_n` edges detected in the same cycle: the `cs_n` edge takes priority and the `sck` edge is ignored.
  - Watchdog expiry in the same cycle as COMMIT of a valid frame: the commit wins, and `timeout` stays 0.
- **Reset, including mid-frame**:
  - All outputs go to 0 and the FSM goes to WAIT_IDLE.
  - Shift register, counters and watchdog clear.
  - The partial frame is dropped silently, with no `frame_error`.

## Timing
- Reset values: `sdo`=0, `motor1_sign`=0, `motor1_count`=0, `motor2_sign`=0, `motor2_count`=0, `cmd_valid`=0, `frame_error`=0, `timeout`=0.
- Pin-to-detect latency: 3 `clk` edges (2 sync + 1 edge flop).
- `cs_n` rising pin to updated outputs and the `cmd_valid` pulse: exactly 4 `clk` edges. Outputs and `cmd_valid` change on the same edge.
- `frame_error` has the same latency as `cmd_valid`.
- `sdo` changes 3 `clk` edges after the `sck` falling pin. At the 8x ratio this leaves at least 1 `clk` of setup before the next `sck` rise.
- Minimum `cs_n`-high gap between frames: 4 `clk` cycles.
- `timeout` asserts on the clock edge where the watchdog count equals TIMEOUT_CYCLES. Counts read 0 in that same cycle.

## Test plan
- **Basic command**: reset, then send 0xE4_32 (m1 sign=1, count=100; m2 sign=0, count=50).
  - Outputs read 1/100/0/50 exactly 4 `clk` after `cs_n` rises.
  - `cmd_valid` is high for one cycle.
- **Clamp and echo**:
  - Send 0x7F_FF. Counts read 100/100 with signs 0/1.
  - Next frame: `sdo` shifts out 0x64_E4 MSB first, sampled on `sck` rising edges.
- **Short and long frames**:
  - 15-bit frame: `frame_error` pulse, outputs unchanged.
  - 17-bit frame: `frame_error` pulse, outputs unchanged.
  - A following 16-bit frame commits normally.
- **Watchdog**, with TIMEOUT_CYCLES=1000:
  - Commit 0xE4_B2, then idle 1000 cycles. `timeout`=1, counts 0, signs 1/1.
  - Next valid frame clears `timeout`.
- **Reset mid-frame**:
  - Assert `reset` after 8 bits. All outputs read 0; no `cmd_valid` or `frame_error`.
  - Remaining bits while `cs_n` is still low are ignored.
  - The next full frame after `cs_n` goes high commits.
- **Simultaneous edges**: drive the `sck` rise and `cs_n` rise into the same sync cycle after 16 bits. The frame commits with 16 bits, and no 17th bit is counted.
